reg16_file_idu: RTL and testbench

- 16-bit register file plus increment/decrement unit (IDU) for the CPU datapath.
- Consumer of the microcode 16-bit control bundle. Microcode blocks drive Read16, Write16, Address_Out, Increment16 and IR_Fetch; this block decodes them, moves data between register pairs and drives the external address bus.
- Also supplies 8-bit access to the byte halves for the ALU/data-bus path.

---
 rtl/gbc_cpu_pkg.sv | 38 +++
 rtl/idu16.sv | 20 ++
 rtl/reg16_file_idu.sv | 111 +++++++++++
 tb/tb_reg16_file_idu.sv | 134 +++++++++++++
 4 files changed

// File: rtl/gbc_cpu_pkg.sv
// gbc_cpu_pkg: shared register-pair/byte indices, IDU op encoding and reset defaults for the CPU datapath
package gbc_cpu_pkg;

    localparam int R16_BC = 0;
    localparam int R16_DE = 1;
    localparam int R16_WZ = 2;
    localparam int R16_HL = 3;
    localparam int R16_SP = 4;
    localparam int R16_PC = 5;

    localparam logic [2:0] R8_B = 3'd0;
    localparam logic [2:0] R8_C = 3'd1;
    localparam logic [2:0] R8_D = 3'd2;
    localparam logic [2:0] R8_E = 3'd3;
    localparam logic [2:0] R8_H = 3'd4;
    localparam logic [2:0] R8_L = 3'd5;
    localparam logic [2:0] R8_W = 3'd6;
    localparam logic [2:0] R8_Z = 3'd7;

    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] DEF_RESET_SP = 16'hFFFE;

    // {dec, inc} as driven by microcode on Increment16
    typedef enum logic [1:0] {
        IDU_HOLD = 2'b00,
        IDU_INC  = 2'b01,
        IDU_DEC  = 2'b10,
        IDU_BOTH = 2'b11
    } idu_op_e;

    // Pair that holds a given byte; even byte indices are the high halves
    function automatic int r8_pair(logic [2:0] sel);
        return (sel[2:1] == 2'd0) ? R16_BC :
               (sel[2:1] == 2'd1) ? R16_DE :
               (sel[2:1] == 2'd2) ? R16_HL : R16_WZ;
    endfunction

endpackage

// File: rtl/idu16.sv
// idu16: combinational 16-bit +1/-1 unit; inc and dec together cancel to a pass-through
module idu16
    import gbc_cpu_pkg::*;
(
    input  logic [15:0] src,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] result
);

    idu_op_e op;

    // Wrap-around arithmetic is intentional: FFFF+1 = 0000, 0000-1 = FFFF
    always_comb begin
        op     = idu_op_e'({dec, inc});
        result = (op == IDU_INC) ? src + 16'd1 :
                 (op == IDU_DEC) ? src - 16'd1 : src;
    end

endmodule

// File: rtl/reg16_file_idu.sv
// reg16_file_idu: 16-bit register file, IDU and address latch; optional GBC_REG16_SEL_CHECK_EN adds o_Sel_Error
module reg16_file_idu
    import gbc_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEF_RESET_PC,
    parameter logic [15:0] RESET_SP = DEF_RESET_SP
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic [5:0]  i_Read16,
    input  logic [5:0]  i_Write16,
    input  logic [1:0]  i_Increment16,
    input  logic        i_Address_Out,
    input  logic        i_IR_Fetch,
    input  logic [7:0]  i_Write8,
    input  logic [7:0]  i_Data8,
    input  logic [2:0]  i_Read8_Sel,
    output logic [7:0]  o_Read8,
    output logic [15:0] o_Address,
    output logic [15:0] o_Bus16
`ifdef GBC_REG16_SEL_CHECK_EN
    ,
    output logic        o_Sel_Error
`endif
);

    logic [15:0] r [6];
    logic [15:0] src;
    int          rd_pair;

    // Source mux: lowest set Read16 bit wins, none selected gives zero
    always_comb begin
        src = i_Read16[R16_BC] ? r[R16_BC] :
              i_Read16[R16_DE] ? r[R16_DE] :
              i_Read16[R16_WZ] ? r[R16_WZ] :
              i_Read16[R16_HL] ? r[R16_HL] :
              i_Read16[R16_SP] ? r[R16_SP] :
              i_Read16[R16_PC] ? r[R16_PC] : 16'h0000;
    end

    idu16 u_idu (
        .src    (src),
        .inc    (i_Increment16[0]),
        .dec    (i_Increment16[1]),
        .result (o_Bus16)
    );

    // Byte read path shows pre-edge register state, no bypass
    always_comb begin
        rd_pair = r8_pair(i_Read8_Sel);
        o_Read8 = i_Read8_Sel[0] ? r[rd_pair][7:0] : r[rd_pair][15:8];
    end

    // Register file update: byte writes first so a same-cycle pair write overrides them
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            for (int p = 0; p < 4; p++) r[p] <= 16'h0000;
            r[R16_SP] <= RESET_SP;
            r[R16_PC] <= RESET_PC;
        end else begin
            for (int s = 0; s < 8; s++) begin
                if (i_Write8[3'(7 - s)]) begin
                    if (s[0]) r[r8_pair(s[2:0])][7:0]  <= i_Data8;
                    else      r[r8_pair(s[2:0])][15:8] <= i_Data8;
                end
            end
            for (int p = 0; p < 5; p++) begin
                if (i_Write16[p]) r[p] <= o_Bus16;
            end
            if (i_Write16[R16_PC])
                r[R16_PC] <= o_Bus16;
            else if (i_IR_Fetch && !i_Address_Out)
                r[R16_PC] <= r[R16_PC] + 16'd1;
        end
    end

    // Address latch: explicit Address_Out beats an opcode fetch
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n)
            o_Address <= RESET_PC;
        else if (i_Address_Out)
            o_Address <= src;
        else if (i_IR_Fetch)
            o_Address <= r[R16_PC];
    end

`ifdef GBC_REG16_SEL_CHECK_EN
    logic multi_sel;
    logic both_op;

    assign multi_sel = (i_Read16 & (i_Read16 - 6'd1)) != 6'd0;
    assign both_op   = i_Increment16 == IDU_BOTH;

    // Sticky flag for malformed microcode selections, cleared only by reset
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n)
            o_Sel_Error <= 1'b0;
        else if (multi_sel || both_op)
            o_Sel_Error <= 1'b1;
    end

`ifndef SYNTHESIS
    // Simulation-time report of the same malformed selections
    always_ff @(posedge i_Clk) begin
        if (i_Reset_n && multi_sel) $error("reg16_file_idu: multiple Read16 bits set: %b", i_Read16);
        if (i_Reset_n && both_op) $error("reg16_file_idu: Increment16 inc and dec both set");
    end
`endif
`endif

endmodule

// File: tb/tb_reg16_file_idu.sv
// tb_reg16_file_idu: table-driven directed check of reg16_file_idu
module tb_reg16_file_idu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rd16, wr16;
    logic [1:0]  inc;
    logic        ao, fe;
    logic [7:0]  wr8, d8;
    logic [2:0]  sel;
    logic [7:0]  read8;
    logic [15:0] address, bus16;
    logic        sel_err;

    int errors = 0;
    int checks = 0;

    reg16_file_idu dut (
        .i_Clk         (clk),
        .i_Reset_n     (rst_n),
        .i_Read16      (rd16),
        .i_Write16     (wr16),
        .i_Increment16 (inc),
        .i_Address_Out (ao),
        .i_IR_Fetch    (fe),
        .i_Write8      (wr8),
        .i_Data8       (d8),
        .i_Read8_Sel   (sel),
        .o_Read8       (read8),
        .o_Address     (address),
        .o_Bus16       (bus16)
`ifdef GBC_REG16_SEL_CHECK_EN
        ,
        .o_Sel_Error   (sel_err)
`endif
    );

`ifndef GBC_REG16_SEL_CHECK_EN
    assign sel_err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [5:0]  rd16;
        logic [5:0]  wr16;
        logic [1:0]  inc;
        logic        ao;
        logic        fe;
        logic [7:0]  wr8;
        logic [7:0]  d8;
        logic [2:0]  sel;
        logic [15:0] exp_bus;
        logic [7:0]  exp_r8;
        logic [15:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t tv[$];

    task automatic check16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        // rst, rd16, wr16, inc, ao, fe, wr8, d8, sel, exp_bus, exp_r8, exp_addr, exp_err(after edge)
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'hFFFE, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd7, 16'h0000, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h08, 8'hC1, 3'd4, 16'h0000, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h04, 8'h23, 3'd4, 16'h0000, 8'hC1, 16'h0000, 0});
        tv.push_back('{1, 6'b001000, 6'b010000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd5, 16'hC123, 8'h23, 16'h0000, 0});
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd4, 16'hC123, 8'hC1, 16'h0000, 0});
        tv.push_back('{1, 6'b001000, 6'b000000, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 16'hC124, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h08, 8'h40, 3'd4, 16'h0000, 8'hC1, 16'h0000, 0});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h04, 8'h00, 3'd4, 16'h0000, 8'h40, 16'h0000, 0});
        tv.push_back('{1, 6'b001000, 6'b100000, 2'b01, 1, 1, 8'h00, 8'h00, 3'd5, 16'h4001, 8'h00, 16'h4000, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'h4001, 8'h00, 16'h4000, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 1, 8'h00, 8'h00, 3'd0, 16'h4001, 8'h00, 16'h4001, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'h4002, 8'h00, 16'h4001, 0});
        tv.push_back('{1, 6'b000000, 6'b100000, 2'b10, 0, 0, 8'h00, 8'h00, 3'd0, 16'hFFFF, 8'h00, 16'h4001, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 1, 8'h00, 8'h00, 3'd0, 16'hFFFF, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'h0000, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b000000, 6'b010000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'h0000, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b010000, 6'b010000, 2'b10, 0, 0, 8'h00, 8'h00, 3'd0, 16'hFFFF, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'hFFFF, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 16'h0000, 8'h00, 16'hFFFF, 0});
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b11, 0, 0, 8'h00, 8'h00, 3'd0, 16'hFFFF, 8'h00, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h02, 8'hBE, 3'd6, 16'h0000, 8'h00, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000000, 6'b000000, 2'b00, 0, 0, 8'h01, 8'hEF, 3'd6, 16'h0000, 8'hBE, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000100, 6'b000010, 2'b00, 0, 0, 8'h20, 8'h11, 3'd2, 16'hBEEF, 8'h00, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000010, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd2, 16'hBEEF, 8'hBE, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000011, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 16'h0000, 8'h00, 16'hFFFF, 1});
        tv.push_back('{1, 6'b001100, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd7, 16'hBEEF, 8'hEF, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000100, 6'b001001, 2'b01, 0, 0, 8'h00, 8'h00, 3'd0, 16'hBEF0, 8'h00, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000001, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd1, 16'hBEF0, 8'hF0, 16'hFFFF, 1});
        tv.push_back('{1, 6'b001000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd5, 16'hBEF0, 8'hF0, 16'hFFFF, 1});
        tv.push_back('{1, 6'b000010, 6'b000000, 2'b00, 1, 0, 8'h00, 8'h00, 3'd4, 16'hBEEF, 8'hBE, 16'hBEEF, 1});
        tv.push_back('{0, 6'b000010, 6'b111111, 2'b01, 1, 1, 8'hFF, 8'h55, 3'd3, 16'hBEF0, 8'hEF, 16'h0000, 0});
        tv.push_back('{1, 6'b010000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd2, 16'hFFFE, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b000010, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd3, 16'h0000, 8'h00, 16'h0000, 0});
        tv.push_back('{1, 6'b100000, 6'b000000, 2'b00, 0, 0, 8'h00, 8'h00, 3'd6, 16'h0000, 8'h00, 16'h0000, 0});

        rst_n = 1'b0; rd16 = '0; wr16 = '0; inc = '0; ao = 1'b0; fe = 1'b0;
        wr8 = '0; d8 = '0; sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check16("reset_addr", -1, address, 16'h0000);
        check16("reset_err", -1, {15'd0, sel_err}, 16'h0000);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; rd16 = tv[i].rd16; wr16 = tv[i].wr16; inc = tv[i].inc;
            ao = tv[i].ao; fe = tv[i].fe; wr8 = tv[i].wr8; d8 = tv[i].d8; sel = tv[i].sel;
            #1;
            check16("bus16", i, bus16, tv[i].exp_bus);
            check16("read8", i, {8'd0, read8}, {8'd0, tv[i].exp_r8});
            @(posedge clk);
            #1;
            check16("address", i, address, tv[i].exp_addr);
`ifdef GBC_REG16_SEL_CHECK_EN
            check16("sel_err", i, {15'd0, sel_err}, {15'd0, tv[i].exp_err});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
